dm_port_arbiter: RTL and testbench
==================================

# dm_port_arbiter

Two-master arbiter that shares the single data-memory port between the CPU M-stage access path and a DMA copy engine. It sits between the bridge's DM-side outputs (address, byteen, write data, read data) and the external `m_data_*` bus. The CPU has priority; a starvation counter guarantees DMA progress, and a bounded lock mode lets DMA issue short bursts. When the CPU loses arbitration, the arbiter raises a stall that freezes the pipeline.

## Interface
Parameters:
- `STARVE_MAX`, default 4: number of consecutive denied DMA cycles after which DMA wins over CPU (range 1..15).
- `BURST_MAX`, default 8: maximum consecutive locked DMA beats (range 1..15).

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `cpu_req` input 1: CPU M-stage DM access this cycle (load or store).
- `cpu_addr` input 32: CPU byte address.
- `cpu_wdata` input 32: CPU write data, already lane-aligned.
- `cpu_byteen` input 4: CPU byte enables; 0 means read.
- `cpu_rdata` output 32: read data to CPU, equal to `mem_rdata`.
- `cpu_stall` output 1: CPU request not granted this cycle; the pipeline holds M and earlier stages.
- `dma_req` input 1: DMA access request.
- `dma_lock` input 1: DMA asks to keep ownership on the following cycle.
- `dma_addr` input 32, `dma_wdata` input 32, `dma_byteen` input 4: DMA access, with the same meaning as the CPU fields.
- `dma_gnt` output 1: DMA access performed this cycle.
- `dma_rdata` output 32: equal to `mem_rdata`.
- `mem_addr` output 32, `mem_wdata` output 32, `mem_byteen` output 4: toward `m_data_addr`, `m_data_wdata`, `m_data_byteen`.
- `mem_rdata` input 32: from `m_data_rdata`; valid in the same cycle as the address.
- `owner` output 1: 0 means CPU drives the port, 1 means DMA.

## Operation
- State register `st` has two states: ARB and LOCK.
- Counters: `starve` (4 bits) and `beats` (4 bits).
- Grant is combinational from `st`, the counters and the current requests. Exactly one master or none is granted each cycle.
- In ARB, DMA is granted when `dma_req` is high and either `cpu_req` is low or `starve == STARVE_MAX`. Otherwise the CPU is granted if `cpu_req` is high.
- In LOCK, DMA is granted when `dma_req` is high. The CPU is never granted, and `cpu_stall = cpu_req`.
- Port mux:
  - With a grant, `mem_addr`, `mem_wdata` and `mem_byteen` come from the granted master.
  - With no grant, `mem_byteen = 0`, `mem_addr = cpu_addr` and `mem_wdata = 0`.
  - The ungranted master's byteen never reaches memory.
- Outputs: `cpu_stall = cpu_req & ~cpu_granted`. `dma_gnt = dma granted`. `owner = dma_gnt`.
- Starvation counter `starve`:
  - Increments when `dma_req` is high and DMA is not granted, saturating at `STARVE_MAX`.
  - Clears on a DMA grant or whenever `dma_req` is low.
- Transitions and beat counter `beats`:
  - ARB to LOCK: on a DMA grant with `dma_lock` high and `BURST_MAX > 1`. Set `beats = 1`.
  - LOCK to LOCK: on a DMA grant with `dma_lock` high and `beats + 1 < BURST_MAX`. Increment `beats`.
  - LOCK to ARB: otherwise, i.e. `dma_req` low, `dma_lock` low, or the burst limit reached. Clear `beats`.
  - The LOCK-to-ARB decision uses the current cycle's inputs. The beat granted in that cycle still completes.
- After leaving LOCK, the first ARB cycle applies normal CPU priority. The burst itself cleared `starve`, so a waiting CPU wins.
- Simultaneous events: if `cpu_req` and `dma_req` arrive together with `starve < STARVE_MAX`, the CPU wins and `starve` increments.
- While `reset` is low:
  - `st = ARB` and both counters are 0.
  - `dma_gnt`, `cpu_stall`, `owner` and `mem_byteen` are forced to 0.
  - `mem_addr` and `mem_wdata` are forced to 0.
- Reset asserted mid-burst aborts LOCK immediately, asynchronously.

## Timing
- Zero-cycle arbitration: grant and mux settle combinationally within the request cycle.
- Writes commit at the rising edge that ends the granted cycle. Read data is valid in the same cycle.
- A stalled CPU access repeats unchanged each cycle until granted. Worst-case CPU wait is `BURST_MAX` cycles.
- Worst-case DMA wait under continuous CPU traffic is `STARVE_MAX + 1` cycles.
- No combinational path from `mem_rdata` to any control output.

## Test plan
- **Reset.** Hold `reset` low with `cpu_req = dma_req = 1`: `mem_byteen = 0`, `cpu_stall = 0`, `dma_gnt = 0`. Release: the first cycle grants the CPU.
- **CPU only.** CPU store to 0x00000010 with byteen 4'b1111 and data 0xDEADBEEF: `mem_*` follows the CPU, `cpu_stall = 0`, `owner = 0`.
- **Starvation.** `STARVE_MAX = 4`, with `cpu_req` and `dma_req` held high, `dma_lock = 0`:
  - Cycles 1–4 grant the CPU.
  - Cycle 5 grants DMA with `cpu_stall = 1`.
  - The pattern then repeats with period 5.
- **Locked burst.** `BURST_MAX = 8`, `dma_lock = 1`, `cpu_req = 1` throughout: DMA owns exactly 8 consecutive cycles with `cpu_stall = 1`, then the CPU is granted for 4 cycles.
- **Early unlock.** Drop `dma_lock` on beat 3: beat 3 completes and the CPU is granted on the next cycle.
- **Reset mid-burst.** Assert `reset` on beat 2: `dma_gnt` drops immediately. After release, state is ARB and `starve = 0`.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
// ---------------------------------------------------------------------------
// Shares the single data-memory port between the CPU M-stage access path and
// a DMA copy engine. The CPU has priority. A starvation counter makes sure the
// DMA still makes progress under continuous CPU traffic, and a bounded lock
// mode lets the DMA issue short uninterrupted bursts. The grant and the port
// mux are combinational in the request cycle. When the CPU loses arbitration,
// cpu_stall freezes the pipeline.
//
// Ports
//   clk, reset             : rising-edge clock, asynchronous active-low reset
//   cpu_req/addr/wdata/byteen, cpu_rdata, cpu_stall : CPU M-stage access
//   dma_req/lock/addr/wdata/byteen, dma_gnt, dma_rdata : DMA access
//   mem_addr/wdata/byteen  : toward m_data_addr / m_data_wdata / m_data_byteen
//   mem_rdata              : from m_data_rdata, valid in the same cycle
//   owner                  : 0 = CPU drives the port, 1 = DMA
// ---------------------------------------------------------------------------
module dm_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4,  // 1..15
  parameter int unsigned BURST_MAX  = 8   // 1..15
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byteen,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,

  input  logic        dma_req,
  input  logic        dma_lock,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [3:0]  dma_byteen,
  output logic        dma_gnt,
  output logic [31:0] dma_rdata,

  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteen,
  input  logic [31:0] mem_rdata,

  output logic        owner
);

  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [4:0] BURST_LIM  = 5'(BURST_MAX);
  localparam bit         BURST_EN   = (BURST_MAX > 1);

  logic [0:0] st, st_nxt;
  logic [3:0] starve, starve_nxt;
  logic [3:0] beats, beats_nxt;

  logic cpu_win, dma_win;
  logic cpu_g, dma_g;

  // -------------------------------------------------------------------------
  // Grant decision
  // -------------------------------------------------------------------------
  always_comb begin
    cpu_win = 1'b0;
    dma_win = 1'b0;
    if (st == ST_LOCK) begin
      dma_win = dma_req;
    end else begin
      dma_win = dma_req & (~cpu_req | (starve == STARVE_LIM));
      cpu_win = cpu_req & ~dma_win;
    end
  end

  // The reset level gates the grants directly. Grants, stall and the port
  // therefore go quiet the moment reset is asserted, even in the middle of
  // a locked burst, without waiting for the state register to clear.
  assign dma_g = dma_win & reset;
  assign cpu_g = cpu_win & reset;

  assign dma_gnt   = dma_g;
  assign owner     = dma_g;
  assign cpu_stall = reset & cpu_req & ~cpu_g;

  assign cpu_rdata = mem_rdata;
  assign dma_rdata = mem_rdata;

  // -------------------------------------------------------------------------
  // Port mux: the byte enables of the master that was not granted never
  // reach memory. With no grant the address idles on the CPU address.
  // -------------------------------------------------------------------------
  always_comb begin
    mem_addr   = reset ? cpu_addr : '0;
    mem_wdata  = '0;
    mem_byteen = '0;
    if (dma_g) begin
      mem_addr   = dma_addr;
      mem_wdata  = dma_wdata;
      mem_byteen = dma_byteen;
    end else if (cpu_g) begin
      mem_addr   = cpu_addr;
      mem_wdata  = cpu_wdata;
      mem_byteen = cpu_byteen;
    end
  end

  // -------------------------------------------------------------------------
  // Starvation counter: counts consecutive denied DMA cycles and saturates
  // at the limit, where the DMA beats the CPU.
  // -------------------------------------------------------------------------
  always_comb begin
    starve_nxt = starve;
    if (dma_g || !dma_req) begin
      starve_nxt = '0;
    end else if (starve < STARVE_LIM) begin
      starve_nxt = starve + 4'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Lock state and beat counter. The beat counter holds the number of beats
  // already completed in the burst. The beat granted in the exit cycle still
  // completes, because the exit decision only affects the next cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    st_nxt    = st;
    beats_nxt = beats;
    case (st)
      ST_ARB: begin
        if (dma_g && dma_lock && BURST_EN) begin
          st_nxt    = ST_LOCK;
          beats_nxt = 4'd1;
        end
      end
      default: begin
        if (dma_g && dma_lock && (({1'b0, beats} + 5'd1) < BURST_LIM)) begin
          st_nxt    = ST_LOCK;
          beats_nxt = beats + 4'd1;
        end else begin
          st_nxt    = ST_ARB;
          beats_nxt = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st     <= ST_ARB;
      starve <= '0;
      beats  <= '0;
    end else begin
      st     <= st_nxt;
      starve <= starve_nxt;
      beats  <= beats_nxt;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
module tb_dm_port_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_byteen;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dma_req;
  logic        dma_lock;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [3:0]  dma_byteen;
  logic        dma_gnt;
  logic [31:0] dma_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_rdata;
  logic        owner;

  int unsigned n_chk;
  int unsigned n_fail;

  // Expected {cpu_stall, dma_gnt, owner, mem_byteen, mem_addr, mem_wdata}
  logic [70:0] sb[$];

  localparam logic [31:0] CA = 32'h0000_0010;
  localparam logic [31:0] CW = 32'hDEAD_BEEF;
  localparam logic [3:0]  CB = 4'b1111;
  localparam logic [31:0] DA = 32'h8000_0040;
  localparam logic [31:0] DW = 32'h0BAD_F00D;
  localparam logic [3:0]  DB = 4'b0011;

  dm_port_arbiter #(
    .STARVE_MAX(4),
    .BURST_MAX (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_byteen(cpu_byteen),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dma_req   (dma_req),
    .dma_lock  (dma_lock),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_byteen(dma_byteen),
    .dma_gnt   (dma_gnt),
    .dma_rdata (dma_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_byteen(mem_byteen),
    .mem_rdata (mem_rdata),
    .owner     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [70:0] pk(input logic stall, input logic gnt,
                                     input logic [3:0] be, input logic [31:0] a,
                                     input logic [31:0] w);
    return {stall, gnt, gnt, be, a, w};
  endfunction

  function automatic logic [70:0] exp_cpu();
    return pk(1'b0, 1'b0, CB, CA, CW);
  endfunction

  function automatic logic [70:0] exp_dma(input logic stall);
    return pk(stall, 1'b1, DB, DA, DW);
  endfunction

  function automatic logic [70:0] exp_idle();
    return pk(1'b0, 1'b0, 4'b0000, CA, 32'h0);
  endfunction

  function automatic logic [70:0] act_out();
    return {cpu_stall, dma_gnt, owner, mem_byteen, mem_addr, mem_wdata};
  endfunction

  task automatic set_in(input logic cr, input logic dr, input logic dl);
    cpu_req  = cr;
    dma_req  = dr;
    dma_lock = dl;
  endtask

  // One idle cycle: returns the arbiter to ARB with a cleared starve count.
  task automatic test_idle(input string tag);
    logic [70:0] e;
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 1'b0);
    sb.push_back(exp_idle());
    @(negedge clk);
    e = sb.pop_front();
    n_chk++;
    if (act_out() !== e) begin
      n_fail++;
      $display("FAIL %s idle: got %h want %h", tag, act_out(), e);
    end
  endtask

  task automatic test_reset();
    logic [70:0] e;
    set_in(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    n_chk++;
    if (act_out() !== pk(1'b0, 1'b0, 4'b0, 32'h0, 32'h0)) begin
      n_fail++;
      $display("FAIL reset_hold: got %h want all zero", act_out());
    end
    @(negedge clk);
    n_chk++;
    if ({dma_gnt, cpu_stall, mem_byteen} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_hold2: got gnt=%b stall=%b be=%b want 0", dma_gnt, cpu_stall, mem_byteen);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    set_in(1'b1, 1'b1, 1'b0);
    sb.push_back(exp_cpu());
    @(negedge clk);
    e = sb.pop_front();
    n_chk++;
    if (act_out() !== e) begin
      n_fail++;
      $display("FAIL reset_release: got %h want %h", act_out(), e);
    end
    test_idle("reset");
  endtask

  task automatic test_cpu_only();
    logic [70:0] e;
    // store, read (byteen 0), then no request at a different address
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      mem_rdata = 32'h1234_5670 + 32'(i);
      if (i == 0) begin
        set_in(1'b1, 1'b0, 1'b0);
        sb.push_back(exp_cpu());
      end else if (i == 1) begin
        cpu_byteen = 4'b0000;
        set_in(1'b1, 1'b0, 1'b0);
        sb.push_back(pk(1'b0, 1'b0, 4'b0000, CA, CW));
      end else begin
        cpu_byteen = CB;
        cpu_addr   = 32'h0000_0044;
        set_in(1'b0, 1'b0, 1'b0);
        sb.push_back(pk(1'b0, 1'b0, 4'b0000, 32'h0000_0044, 32'h0));
      end
      @(negedge clk);
      e = sb.pop_front();
      n_chk++;
      if (act_out() !== e) begin
        n_fail++;
        $display("FAIL cpu_only[%0d]: got %h want %h", i, act_out(), e);
      end
      n_chk++;
      if (cpu_rdata !== 32'h1234_5670 + 32'(i) || dma_rdata !== 32'h1234_5670 + 32'(i)) begin
        n_fail++;
        $display("FAIL rdata[%0d]: got cpu=%h dma=%h want %h", i, cpu_rdata, dma_rdata,
                 32'h1234_5670 + 32'(i));
      end
    end
    cpu_addr = CA;
  endtask

  task automatic test_dma_only();
    logic [70:0] e;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      set_in(1'b0, 1'b1, 1'b0);
      sb.push_back(exp_dma(1'b0));
      @(negedge clk);
      e = sb.pop_front();
      n_chk++;
      if (act_out() !== e) begin
        n_fail++;
        $display("FAIL dma_only[%0d]: got %h want %h", i, act_out(), e);
      end
    end
    test_idle("dma_only");
  endtask

  task automatic test_starvation();
    logic [70:0] e;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      set_in(1'b1, 1'b1, 1'b0);
      sb.push_back((i % 5 == 4) ? exp_dma(1'b1) : exp_cpu());
      @(negedge clk);
      e = sb.pop_front();
      n_chk++;
      if (act_out() !== e) begin
        n_fail++;
        $display("FAIL starve[%0d]: got %h want %h", i, act_out(), e);
      end
    end
    test_idle("starve");
  endtask

  task automatic test_burst();
    logic [70:0] e;
    // 4 CPU, 8 locked DMA beats, 4 CPU, then DMA wins again
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      set_in(1'b1, 1'b1, 1'b1);
      sb.push_back(((i >= 4 && i < 12) || i == 16) ? exp_dma(1'b1) : exp_cpu());
      @(negedge clk);
      e = sb.pop_front();
      n_chk++;
      if (act_out() !== e) begin
        n_fail++;
        $display("FAIL burst[%0d]: got %h want %h", i, act_out(), e);
      end
    end
    test_idle("burst");
  endtask

  task automatic test_early_unlock();
    logic [70:0] e;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      set_in(1'b1, 1'b1, (i < 6));
      sb.push_back((i >= 4 && i <= 6) ? exp_dma(1'b1) : exp_cpu());
      @(negedge clk);
      e = sb.pop_front();
      n_chk++;
      if (act_out() !== e) begin
        n_fail++;
        $display("FAIL early_unlock[%0d]: got %h want %h", i, act_out(), e);
      end
    end
    test_idle("early_unlock");
  endtask

  task automatic test_reset_mid_burst();
    logic [70:0] e;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      set_in(1'b0, 1'b1, 1'b1);
      sb.push_back(exp_dma(1'b0));
      @(negedge clk);
      e = sb.pop_front();
      n_chk++;
      if (act_out() !== e) begin
        n_fail++;
        $display("FAIL mid_burst_beat[%0d]: got %h want %h", i, act_out(), e);
      end
    end
    // still inside beat 2
    #1 reset = 1'b0;
    #1;
    n_chk++;
    if (dma_gnt !== 1'b0 || act_out() !== pk(1'b0, 1'b0, 4'b0, 32'h0, 32'h0)) begin
      n_fail++;
      $display("FAIL mid_burst_reset: got gnt=%b out=%h want all zero", dma_gnt, act_out());
    end
    @(posedge clk); #1;
    reset = 1'b1;
    // ARB with starve 0: CPU wins 4 cycles, then DMA
    for (int i = 0; i < 5; i++) begin
      if (i != 0) begin
        @(posedge clk); #1;
      end
      set_in(1'b1, 1'b1, 1'b1);
      sb.push_back((i == 4) ? exp_dma(1'b1) : exp_cpu());
      @(negedge clk);
      e = sb.pop_front();
      n_chk++;
      if (act_out() !== e) begin
        n_fail++;
        $display("FAIL after_reset[%0d]: got %h want %h", i, act_out(), e);
      end
    end
    test_idle("after_reset");
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    reset      = 1'b0;
    cpu_req    = 1'b0;
    cpu_addr   = CA;
    cpu_wdata  = CW;
    cpu_byteen = CB;
    dma_req    = 1'b0;
    dma_lock   = 1'b0;
    dma_addr   = DA;
    dma_wdata  = DW;
    dma_byteen = DB;
    mem_rdata  = 32'h0;

    test_reset();
    test_cpu_only();
    test_dma_only();
    test_starvation();
    test_burst();
    test_early_unlock();
    test_reset_mid_burst();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
